// File: rtl/main_net_weight_bank.sv
// Main-network weight store: registered read port, in-order update-weight stream
// absorption with ordering check, word counting and completion pulse.
module main_net_weight_bank #(
    parameter int unsigned DATA_WIDTH                    = 32,
    parameter int unsigned LAYER_WIDTH                   = 2,
    parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_weight_valid_request,
    input  logic [LAYER_WIDTH-1:0] i_weight_layer_request,
    input  logic [10:0]            i_weight_addr_request,
    output logic                   o_weight_valid,
    output logic [LAYER_WIDTH-1:0] o_weight_layer,
    output logic [10:0]            o_weight_addr,
    output logic [DATA_WIDTH-1:0]  o_weight,
    input  logic                   i_new_weight_valid,
    input  logic [LAYER_WIDTH-1:0] i_new_weight_layer,
    input  logic [10:0]            i_new_weight_addr,
    input  logic [DATA_WIDTH-1:0]  i_new_weight,
    output logic                   o_busy,
    output logic                   o_update_done,
    output logic                   o_seq_error,
    output logic                   o_addr_error
);

    localparam int unsigned WEIGHT_COUNTER_WIDTH = 11;
    localparam int unsigned SIZE_L1 = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
    localparam int unsigned SIZE_L2 = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
    localparam int unsigned SIZE_L3 = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
    localparam int unsigned TOTAL_WEIGHT = SIZE_L1 + SIZE_L2 + SIZE_L3;
    localparam int unsigned AW1 = $clog2(SIZE_L1);
    localparam int unsigned AW2 = $clog2(SIZE_L2);
    localparam int unsigned AW3 = $clog2(SIZE_L3);

    typedef enum logic {
        S_IDLE,
        S_LOADING
    } state_t;

    logic [DATA_WIDTH-1:0] r_l1 [SIZE_L1];
    logic [DATA_WIDTH-1:0] r_l2 [SIZE_L2];
    logic [DATA_WIDTH-1:0] r_l3 [SIZE_L3];

    state_t                          r_state;
    logic [LAYER_WIDTH-1:0]          r_exp_layer;
    logic [WEIGHT_COUNTER_WIDTH-1:0] r_exp_addr;
    logic [WEIGHT_COUNTER_WIDTH-1:0] r_count;

    logic                            w_rd_ok;
    logic                            w_wr_ok;
    logic                            w_wr_in_order;
    logic [LAYER_WIDTH-1:0]          w_next_layer;
    logic [WEIGHT_COUNTER_WIDTH-1:0] w_next_addr;

    // Number of words in a layer; the invalid tag 0 has no words.
    function automatic int unsigned layer_size(input logic [LAYER_WIDTH-1:0] layer);
        case (layer)
            LAYER_WIDTH'(1): return SIZE_L1;
            LAYER_WIDTH'(2): return SIZE_L2;
            LAYER_WIDTH'(3): return SIZE_L3;
            default:         return 0;
        endcase
    endfunction

    assign w_rd_ok = 32'(i_weight_addr_request) < layer_size(i_weight_layer_request);
    assign w_wr_ok = i_new_weight_valid &&
                     (32'(i_new_weight_addr) < layer_size(i_new_weight_layer));
    assign w_wr_in_order = (i_new_weight_layer == r_exp_layer) && (i_new_weight_addr == r_exp_addr);

    // Word following the incoming write in stream order (also the resync target).
    always_comb begin
        w_next_layer = i_new_weight_layer;
        w_next_addr  = i_new_weight_addr + WEIGHT_COUNTER_WIDTH'(1);
        if (32'(i_new_weight_addr) == layer_size(i_new_weight_layer) - 1) begin
            w_next_addr  = '0;
            w_next_layer = (i_new_weight_layer == LAYER_WIDTH'(3)) ? LAYER_WIDTH'(1)
                                                                    : i_new_weight_layer + LAYER_WIDTH'(1);
        end
    end

    // Weight RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            case (i_new_weight_layer)
                LAYER_WIDTH'(1): r_l1[i_new_weight_addr[AW1-1:0]] <= i_new_weight;
                LAYER_WIDTH'(2): r_l2[i_new_weight_addr[AW2-1:0]] <= i_new_weight;
                LAYER_WIDTH'(3): r_l3[i_new_weight_addr[AW3-1:0]] <= i_new_weight;
                default: ;
            endcase
        end
    end

    // Read response, error flags and stream-tracking FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_exp_layer    <= LAYER_WIDTH'(1);
            r_exp_addr     <= '0;
            r_count        <= '0;
            o_weight_valid <= 1'b0;
            o_weight_layer <= '0;
            o_weight_addr  <= '0;
            o_weight       <= '0;
            o_busy         <= 1'b0;
            o_update_done  <= 1'b0;
            o_seq_error    <= 1'b0;
            o_addr_error   <= 1'b0;
        end else begin
            o_update_done  <= 1'b0;
            o_weight_valid <= i_weight_valid_request;

            if (i_weight_valid_request) begin
                o_weight_layer <= i_weight_layer_request;
                o_weight_addr  <= i_weight_addr_request;
                o_weight       <= '0;
                if (w_rd_ok) begin
                    case (i_weight_layer_request)
                        LAYER_WIDTH'(1): o_weight <= r_l1[i_weight_addr_request[AW1-1:0]];
                        LAYER_WIDTH'(2): o_weight <= r_l2[i_weight_addr_request[AW2-1:0]];
                        LAYER_WIDTH'(3): o_weight <= r_l3[i_weight_addr_request[AW3-1:0]];
                        default:         o_weight <= '0;
                    endcase
                end
            end

            if ((i_weight_valid_request && !w_rd_ok) || (i_new_weight_valid && !w_wr_ok)) begin
                o_addr_error <= 1'b1;
            end

            if (w_wr_ok) begin
                if (!w_wr_in_order) begin
                    o_seq_error <= 1'b1;
                end
                r_exp_layer <= w_next_layer;
                r_exp_addr  <= w_next_addr;
                case (r_state)
                    S_IDLE: begin
                        r_count <= WEIGHT_COUNTER_WIDTH'(1);
                        r_state <= S_LOADING;
                        o_busy  <= 1'b1;
                    end
                    S_LOADING: begin
                        if (r_count == WEIGHT_COUNTER_WIDTH'(TOTAL_WEIGHT - 1)) begin
                            r_count       <= '0;
                            r_exp_layer   <= LAYER_WIDTH'(1);
                            r_exp_addr    <= '0;
                            r_state       <= S_IDLE;
                            o_busy        <= 1'b0;
                            o_update_done <= 1'b1;
                        end else begin
                            r_count <= r_count + WEIGHT_COUNTER_WIDTH'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
